// File: rtl/bcd_scan_decoder_if.sv
// Handshake bundle between the digit datapath and the scanned display decoder.
// The master drives the frame and scan controls; the slave returns the display drive.
interface bcd_scan_decoder_if #(
  parameter int NDIG = 4
);
  logic              en;
  logic              load;
  logic [4*NDIG-1:0] bcd_in;
  logic [NDIG-1:0]   dig_sel;
  logic [9:0]        dec_out;
  logic [NDIG-1:0]   digit_err;
  logic              frame_done;

  modport master (
    output en, load, bcd_in,
    input  dig_sel, dec_out, digit_err, frame_done
  );

  modport slave (
    input  en, load, bcd_in,
    output dig_sel, dec_out, digit_err, frame_done
  );
endinterface

// File: rtl/bcd_scan_decoder.sv
// Time-multiplexed BCD-to-decimal decoder for an NDIG-digit scanned display.
// Double-buffered frame: a load mid-frame waits for the frame wrap so digits never tear.
module bcd_scan_decoder #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 16
) (
  input logic               clk,
  input logic               rst_n,
  bcd_scan_decoder_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state, nxt_state;
  logic [4*NDIG-1:0] disp_reg, nxt_disp;
  logic [4*NDIG-1:0] pend_reg, nxt_pend;
  logic              pend_valid, nxt_pend_valid;
  logic [DIV_W-1:0]  div_cnt, nxt_div;
  logic [IDX_W-1:0]  dig_idx, nxt_idx;
  logic              nxt_done;
  logic              dig_wrap, frame_wrap;

  logic [NDIG-1:0]   dig_sel_q, sel_n;
  logic [9:0]        dec_out_q;
  logic [NDIG-1:0]   digit_err_q;
  logic              frame_done_q;

  function automatic logic [3:0] digit_of(input logic [4*NDIG-1:0] frame,
                                          input logic [IDX_W-1:0]  idx);
    digit_of = frame[4*idx +: 4];
  endfunction

  function automatic logic [9:0] bcd_decode(input logic [3:0] d);
    bcd_decode = (d <= 4'd9) ? (10'd1 << d) : 10'd0;
  endfunction

  function automatic logic [NDIG-1:0] digit_flags(input logic [4*NDIG-1:0] frame);
    digit_flags = '0;
    for (int i = 0; i < NDIG; i++) begin
      digit_flags[i] = (frame[4*i +: 4] > 4'd9);
    end
  endfunction

  assign dig_wrap   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_wrap = dig_wrap && (dig_idx == IDX_W'(NDIG - 1));

  always_comb begin
    nxt_state      = state;
    nxt_disp       = disp_reg;
    nxt_pend       = pend_reg;
    nxt_pend_valid = pend_valid;
    nxt_div        = div_cnt;
    nxt_idx        = dig_idx;
    nxt_done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          nxt_disp       = bus.bcd_in;
          nxt_pend_valid = 1'b0;
        end
        if (bus.en) begin
          nxt_state = SCAN;
          nxt_div   = '0;
          nxt_idx   = '0;
        end
      end
      SCAN: begin
        if (!bus.en) begin
          // Frame buffers survive a pause; only the scan position restarts.
          nxt_state = IDLE;
          nxt_div   = '0;
          nxt_idx   = '0;
          if (bus.load) begin
            nxt_pend       = bus.bcd_in;
            nxt_pend_valid = 1'b1;
          end
        end else begin
          if (dig_wrap) begin
            nxt_div = '0;
            nxt_idx = frame_wrap ? '0 : dig_idx + IDX_W'(1);
          end else begin
            nxt_div = div_cnt + DIV_W'(1);
          end
          if (frame_wrap) begin
            nxt_done = 1'b1;
            if (pend_valid) begin
              nxt_disp       = pend_reg;
              nxt_pend_valid = 1'b0;
            end
          end
          // A load landing on the wrap bypasses the pending buffer and wins over it.
          if (bus.load) begin
            if (frame_wrap) begin
              nxt_disp       = bus.bcd_in;
              nxt_pend_valid = 1'b0;
            end else begin
              nxt_pend       = bus.bcd_in;
              nxt_pend_valid = 1'b1;
            end
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    sel_n = '0;
    if (nxt_state == SCAN) sel_n[nxt_idx] = 1'b1;
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      disp_reg     <= '0;
      pend_reg     <= '0;
      pend_valid   <= 1'b0;
      div_cnt      <= '0;
      dig_idx      <= '0;
      dig_sel_q    <= '0;
      dec_out_q    <= '0;
      digit_err_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= nxt_state;
      disp_reg     <= nxt_disp;
      pend_reg     <= nxt_pend;
      pend_valid   <= nxt_pend_valid;
      div_cnt      <= nxt_div;
      dig_idx      <= nxt_idx;
      dig_sel_q    <= sel_n;
      dec_out_q    <= (nxt_state == SCAN) ? bcd_decode(digit_of(nxt_disp, nxt_idx)) : 10'd0;
      digit_err_q  <= digit_flags(nxt_disp);
      frame_done_q <= nxt_done;
    end
  end

  assign bus.dig_sel    = dig_sel_q;
  assign bus.dec_out    = dec_out_q;
  assign bus.digit_err  = digit_err_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Randomized and directed bench for bcd_scan_decoder against a frame-position reference model.
module tb_bcd_scan_decoder;

  localparam int NDIG     = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = NDIG * SCAN_DIV;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  bcd_scan_decoder_if #(.NDIG(NDIG)) bus ();

  bcd_scan_decoder #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: scan position is cycles elapsed in the current frame.
  bit              m_scan;
  int              m_pos;
  logic [15:0]     m_disp;
  logic [15:0]     m_pend;
  bit              m_pv;
  bit              m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_digit(input int i);
    logic [15:0] f;
    f = m_disp;
    return int'(f[4*i +: 4]);
  endfunction

  function automatic logic [31:0] exp_sel();
    if (!m_scan) return 0;
    return 32'(1) << (m_pos / SCAN_DIV);
  endfunction

  function automatic logic [31:0] exp_dec();
    int d;
    if (!m_scan) return 0;
    d = m_digit(m_pos / SCAN_DIV);
    return (d <= 9) ? (32'(1) << d) : 32'(0);
  endfunction

  function automatic logic [31:0] exp_err();
    logic [31:0] e;
    e = 0;
    for (int i = 0; i < NDIG; i++) if (m_digit(i) > 9) e[i] = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    m_scan = 0; m_pos = 0; m_disp = 0; m_pend = 0; m_pv = 0; m_done = 0;
  endtask

  task automatic model_update(input bit e, input bit l, input logic [15:0] b);
    bit wrapped;
    m_done = 0;
    if (!m_scan) begin
      if (l) begin m_disp = b; m_pv = 0; end
      if (e) begin m_scan = 1; m_pos = 0; end
    end else if (!e) begin
      m_scan = 0;
      m_pos  = 0;
      if (l) begin m_pend = b; m_pv = 1; end
    end else begin
      m_pos   = m_pos + 1;
      wrapped = (m_pos == FRAME);
      if (wrapped) begin
        m_pos  = 0;
        m_done = 1;
        if (m_pv) begin m_disp = m_pend; m_pv = 0; end
      end
      if (l) begin
        if (wrapped) begin m_disp = b; m_pv = 0; end
        else begin m_pend = b; m_pv = 1; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dig_sel"},    32'(bus.dig_sel),    exp_sel());
    check({tag, ".dec_out"},    32'(bus.dec_out),    exp_dec());
    check({tag, ".digit_err"},  32'(bus.digit_err),  exp_err());
    check({tag, ".frame_done"}, 32'(bus.frame_done), 32'(m_done));
  endtask

  task automatic step(input string tag, input bit e, input bit l, input logic [15:0] b);
    bus.en     = e;
    bus.load   = l;
    bus.bcd_in = b;
    @(posedge clk);
    model_update(e, l, b);
    #1;
    check_all(tag);
  endtask

  initial begin
    int guard;
    int done_cnt;
    bit saw5;
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_n      = 1'b0;
    bus.en     = 1'b0;
    bus.load   = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");

    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step("idle", 0, 0, 16'h0);

    // Basic scan of 1234
    step("load1234", 0, 1, 16'h1234);
    step("en_rise", 1, 0, 16'h0);
    check("first_sel", 32'(bus.dig_sel), 32'b0001);
    check("first_dec", 32'(bus.dec_out), 32'b0000010000);
    done_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step("scan1234", 1, 0, 16'h0);
      if (bus.frame_done) done_cnt++;
    end
    check("done_per_frame", 32'(done_cnt), 32'd2);

    // Mid-frame load waits for the wrap
    for (int i = 0; i < 5; i++) step("pre9876", 1, 0, 16'h0);
    step("load9876", 1, 1, 16'h9876);
    for (int i = 0; i < 2 * FRAME; i++) step("scan9876", 1, 0, 16'h0);

    // Invalid code
    step("stop", 0, 0, 16'h0);
    step("load00A5", 0, 1, 16'h00A5);
    check("err_00A5", 32'(bus.digit_err), 32'b0010);
    for (int i = 0; i < FRAME; i++) step("scan00A5", 1, 0, 16'h0);

    // Drop enable on digit 2, then restart with a full dwell
    guard = 0;
    while (exp_sel() != 32'b0100 && guard < 64) begin
      step("seek2", 1, 0, 16'h0);
      guard++;
    end
    check("reach_dig2", 32'(guard < 64), 32'd1);
    step("drop_en", 0, 0, 16'h0);
    check("drop_sel", 32'(bus.dig_sel), 32'd0);
    for (int i = 0; i < 6; i++) step("restart", 1, 0, 16'h0);

    // Load on wrap discards pending 5555
    step("load_pend", 1, 1, 16'h5555);
    guard = 0;
    while (m_pos != FRAME - 1 && guard < 64) begin
      step("seek_wrap", 1, 0, 16'h0);
      guard++;
    end
    check("reach_wrap", 32'(guard < 64), 32'd1);
    step("wrap_load", 1, 1, 16'h4321);
    check("wrap_dec", 32'(bus.dec_out), 32'b0000000010);
    saw5 = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step("post_wrap", 1, 0, 16'h0);
      if (bus.dec_out == 10'b0000100000) saw5 = 1;
    end
    check("never5", 32'(saw5), 32'd0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #3;
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit e, l;
      e = ($urandom_range(0, 15) != 0);
      l = ($urandom_range(0, 7) == 0);
      step("rand", e, l, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
